serial_adder: RTL
=================

# serial_adder

Bit-serial adder that adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first. It feeds the existing single-bit `full_adder` one operand bit pair and the registered carry each cycle, and it consumes that adder's sum and carry outputs. The block is the sequential stage around that combinational cell: operand capture, shifting, carry storage, result assembly and a start/done handshake. It trades WIDTH cycles of latency for a single 1-bit adder cell.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on an accepted start.
- `b`  in  WIDTH  operand B; captured on an accepted start.
- `cin`  in  1  carry-in; captured on an accepted start.
- `busy`  out  1  high while the addition is in progress.
- `done`  out  1  one-cycle pulse marking new `sum`/`cout`.
- `sum`  out  WIDTH  registered result, bits [WIDTH-1:0] of a+b+cin.
- `cout`  out  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation
- Internal state:
  - 2-state FSM: IDLE and RUN.
  - Shift registers `a_sr`, `b_sr` and `s_sr`, each WIDTH bits.
  - 1-bit carry register `c_r`.
  - Bit counter `cnt`, $clog2(WIDTH) bits wide.
- IDLE:
  - `busy` = 0.
  - On `start` = 1: load `a_sr` ← a, `b_sr` ← b, `c_r` ← cin, `cnt` ← 0, then go to RUN.
- RUN, every cycle:
  - One `full_adder` instance computes s = a_sr[0] ^ b_sr[0] ^ c_r and carry co.
  - Update: `a_sr` and `b_sr` shift right by 1; `s_sr` ← {s, s_sr[WIDTH-1:1]}; `c_r` ← co; `cnt` ← cnt+1.
- RUN → IDLE, on the cycle with cnt = WIDTH-1:
  - `sum` ← {s, s_sr[WIDTH-1:1]} and `cout` ← co.
  - `done` ← 1 for exactly one cycle.
- Arithmetic:
  - Result is unsigned modulo 2^(WIDTH+1), split as {cout, sum}.
  - No overflow flag.
- `sum` and `cout` change only at completion or at reset; they hold their last value otherwise.
- `start` while busy is ignored: no capture, no effect on the operation in progress.
- Changes on `a`, `b` or `cin` after capture have no effect.
- `done` and `busy` are never high in the same cycle.
- Reset:
  - Reset = 1 at any edge forces IDLE.
  - It clears `busy`, `done`, `sum`, `cout` and all internal registers to 0.
  - Reset has priority over `start`.
  - Reset during RUN aborts the operation: no `done` is produced and `sum` reads 0.

## Timing
- Reset values: `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
- Let E0 be the edge that samples `start` = 1 in IDLE.
- Bit i (i = 0 … WIDTH-1) is processed at edge E0+1+i.
- `busy` = 1 from just after E0 through edge E0+WIDTH.
- `sum`, `cout` and `done` update at edge E0+WIDTH. `done` is high for the single cycle that follows, and `busy` = 0 in that cycle.
- Latency is WIDTH cycles from start acceptance to `done`.
- Back-to-back operation: `start` = 1 during the `done` cycle is accepted. That edge becomes the new E0, giving a throughput of one result per WIDTH+1 cycles.
- `start` held high continuously repeats the operation every WIDTH+1 cycles.

## Test plan
All scenarios use WIDTH = 8.
- a = 0x5A, b = 0x3C, cin = 0 -> `sum` = 0x96, `cout` = 0; `done` pulses exactly 8 cycles after E0 and `busy` is high for 8 cycles.
- Full-carry ripple:
  - a = 0xFF, b = 0x01, cin = 0 -> `sum` = 0x00, `cout` = 1.
  - a = 0xFF, b = 0xFF, cin = 1 -> `sum` = 0xFF, `cout` = 1.
- Busy protection: start 0x11+0x22, then pulse `start` with a = 0xAA, b = 0xAA at cycle 3 of RUN and change `a` mid-run -> single `done`, `sum` = 0x33, `cout` = 0.
- Reset mid-operation:
  - Start 0xF0+0x0F, then assert reset for 1 cycle at RUN cycle 4 -> next cycle `busy` = 0, `sum` = 0x00, `cout` = 0, and `done` never pulses.
  - A subsequent start of 0x01+0x01 -> `sum` = 0x02.
- Back-to-back and hold:
  - Start 0x80+0x80 (-> `sum` = 0x00, `cout` = 1), with `start` asserted again in its `done` cycle for 0x7F+0x01 (-> `sum` = 0x80, `cout` = 0).
  - Second `done` arrives 9 cycles after the first, and `sum`/`cout` hold between pulses.
- Random sweep: 1000 random (a, b, cin) with random idle gaps -> every `done` shows {cout, sum} = a+b+cin, and `done` is never coincident with `busy`.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit a + b + cin computed LSB first through one
// full_adder cell, one bit per clock, with a start/busy/done handshake.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshake: start is sampled only while idle (busy = 0); a sampled start
// captures a/b/cin, busy stays high for WIDTH cycles, then done pulses for
// one cycle with busy low, and start may be accepted again in that cycle.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, s_sr;
   logic [WIDTH-1:0] s_nxt;
   logic             c_r;
   logic [CNT_W-1:0] cnt;
   logic             fa_s, fa_co;

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (c_r),
      .s  (fa_s),
      .co (fa_co)
   );

   assign s_nxt = {fa_s, s_sr[WIDTH-1:1]};
   assign busy  = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == IDLE) begin
         if (start) state_nxt = RUN;
      end else begin
         if (cnt == LAST_BIT) state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr <= '0;
         b_sr <= '0;
         s_sr <= '0;
         c_r  <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sr <= a;
               b_sr <= b;
               c_r  <= cin;
               cnt  <= '0;
            end
         end else begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_nxt;
            c_r  <= fa_co;
            cnt  <= cnt + CNT_W'(1);
            // Final bit: the result is assembled from the live adder outputs.
            if (cnt == LAST_BIT) begin
               sum  <= s_nxt;
               cout <= fa_co;
               done <= 1'b1;
            end
         end
      end
   end

endmodule
